// File: rtl/fifo_umbral_pkg.sv
// fifo_umbral_pkg: shared defaults and types for the fifo_umbral buffer stage.
// The flow-control FSM instantiates five of these FIFOs (main, VC0, VC1, D0, D1).
package fifo_umbral_pkg;

    // Default geometry: 2-bit destination + 4-bit payload, 16 entries deep
    localparam int DATA_WIDTH_DEF = 6;
    localparam int ADDR_WIDTH_DEF = 4;
    localparam int THR_WIDTH_DEF  = ADDR_WIDTH_DEF + 1;
    localparam int DEPTH_DEF      = 1 << ADDR_WIDTH_DEF;

    // One stored word at the default width
    typedef logic [DATA_WIDTH_DEF-1:0] word_t;

    // Occupancy and threshold values share one width so they compare directly
    typedef logic [THR_WIDTH_DEF-1:0] occ_t;

endpackage : fifo_umbral_pkg

// File: rtl/fifo_umbral_mem.sv
// fifo_umbral_mem: 1-write/1-read register array with a registered read port.
// The array itself is never reset; only the read register clears on reset.
module fifo_umbral_mem
    import fifo_umbral_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Synchronous write; contents carry no reset so the array maps to plain storage
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read; holds the last word whenever no read is requested
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : fifo_umbral_mem

// File: rtl/fifo_umbral.sv
// fifo_umbral: synchronous FIFO with programmable almost-empty/almost-full thresholds.
// Optional build macro FIFO_STICKY_ERR_EN: when defined, error stays set until reset;
// otherwise error pulses for one cycle after each overflow/underflow.
module fifo_umbral
    import fifo_umbral_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int THR_WIDTH  = THR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [THR_WIDTH-1:0]  thr_low,
    input  logic [THR_WIDTH-1:0]  thr_high,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic                  error
);

    localparam int                  DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_MAX = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] wrPtr_q, wrPtr_d;
    logic [ADDR_WIDTH-1:0] rdPtr_q, rdPtr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  empty_q, full_q;
    logic                  almostEmpty_q, almostFull_q;
    logic                  error_q, error_d;
    logic                  validOut_q;

    logic                  pushAcc, popAcc;
    logic                  overflow, underflow;

    // Decide which requests are honoured; a pop on empty is never bypassed from the write
    always_comb begin
        pushAcc   = push && (!full_q || pop);
        popAcc    = pop && !empty_q;
        overflow  = push && full_q && !pop;
        underflow = pop && empty_q;
    end

    // Next pointers and occupancy; simultaneous accepted push and pop leave count unchanged
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (pushAcc) begin
            wrPtr_d = wrPtr_q + PTR_ONE;
        end
        if (popAcc) begin
            rdPtr_d = rdPtr_q + PTR_ONE;
        end
        case ({pushAcc, popAcc})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Error next state: sticky accumulate or single-cycle pulse depending on build
    always_comb begin
`ifdef FIFO_STICKY_ERR_EN
        error_d = error_q | overflow | underflow;
`else
        error_d = overflow | underflow;
`endif
    end

    // Pointer, occupancy and error registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            error_q <= 1'b0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            error_q <= error_d;
        end
    end

    // Status flags are registered from next-cycle occupancy against the live thresholds
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            empty_q       <= 1'b1;
            full_q        <= 1'b0;
            almostEmpty_q <= 1'b1;
            almostFull_q  <= 1'b0;
        end else begin
            empty_q       <= (count_d == '0);
            full_q        <= (count_d == CNT_MAX);
            almostEmpty_q <= (count_d <= thr_low);
            almostFull_q  <= (count_d >= thr_high);
        end
    end

    // valid_out marks that data_out was refreshed by a pop on the previous edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            validOut_q <= 1'b0;
        end else begin
            validOut_q <= popAcc;
        end
    end

    fifo_umbral_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) uMem (
        .clk_i    (clk),
        .reset_ni (reset),
        .we_i     (pushAcc),
        .waddr_i  (wrPtr_q),
        .wdata_i  (data_in),
        .re_i     (popAcc),
        .raddr_i  (rdPtr_q),
        .rdata_o  (data_out)
    );

    assign valid_out    = validOut_q;
    assign count        = count_q;
    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_empty = almostEmpty_q;
    assign almost_full  = almostFull_q;
    assign error        = error_q;

endmodule : fifo_umbral
